// File: rtl/flatten_buffer_layer3_if.sv
// Stream bundle for the layer-3 flatten buffer: 16-channel parallel input side
// and the serial valid/ready output side with its status flags.
interface flatten_buffer_layer3_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_in0;
    logic [DATA_WIDTH-1:0] data_in1;
    logic [DATA_WIDTH-1:0] data_in2;
    logic [DATA_WIDTH-1:0] data_in3;
    logic [DATA_WIDTH-1:0] data_in4;
    logic [DATA_WIDTH-1:0] data_in5;
    logic [DATA_WIDTH-1:0] data_in6;
    logic [DATA_WIDTH-1:0] data_in7;
    logic [DATA_WIDTH-1:0] data_in8;
    logic [DATA_WIDTH-1:0] data_in9;
    logic [DATA_WIDTH-1:0] data_in10;
    logic [DATA_WIDTH-1:0] data_in11;
    logic [DATA_WIDTH-1:0] data_in12;
    logic [DATA_WIDTH-1:0] data_in13;
    logic [DATA_WIDTH-1:0] data_in14;
    logic [DATA_WIDTH-1:0] data_in15;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_out;
    logic                  last_out;
    logic                  in_ready;
    logic                  done;
    logic                  drop_err;

    // Upstream conv/pool stage plus downstream dense layer
    modport master (
        output valid_in,
        output data_in0, data_in1, data_in2, data_in3,
        output data_in4, data_in5, data_in6, data_in7,
        output data_in8, data_in9, data_in10, data_in11,
        output data_in12, data_in13, data_in14, data_in15,
        output ready_out,
        input  data_out, valid_out, last_out, in_ready, done, drop_err
    );

    modport slave (
        input  valid_in,
        input  data_in0, data_in1, data_in2, data_in3,
        input  data_in4, data_in5, data_in6, data_in7,
        input  data_in8, data_in9, data_in10, data_in11,
        input  data_in12, data_in13, data_in14, data_in15,
        input  ready_out,
        output data_out, valid_out, last_out, in_ready, done, drop_err
    );
endinterface

// File: rtl/flatten_buffer_layer3.sv
// Flatten buffer after conv layer 3: captures POSITIONS beats of 16 channel words,
// then streams them out position-major / channel-minor on a valid/ready port.
module flatten_buffer_layer3 #(
    parameter int DATA_WIDTH = 32,
    parameter int POSITIONS  = 16
) (
    input logic                    clk,
    input logic                    resetn,
    flatten_buffer_layer3_if.slave bus
);
    localparam int CHANNELS = 16;
    localparam int WORDS    = POSITIONS * CHANNELS;
    localparam int PW       = $clog2(POSITIONS);
    localparam int RW       = $clog2(WORDS);
    localparam int CW       = $clog2(CHANNELS);

    localparam logic [PW-1:0] POS_LAST = PW'(POSITIONS - 1);
    localparam logic [RW-1:0] RD_LAST  = RW'(WORDS - 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [PW-1:0]         pos_cnt;
    logic [RW-1:0]         rd_idx;
    logic                  done_q;
    logic                  drop_err_q;
    logic [DATA_WIDTH-1:0] ch [CHANNELS];
    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic fill_fire;
    logic fill_last;
    logic xfer;
    logic last_word;

    assign ch[0]  = bus.data_in0;
    assign ch[1]  = bus.data_in1;
    assign ch[2]  = bus.data_in2;
    assign ch[3]  = bus.data_in3;
    assign ch[4]  = bus.data_in4;
    assign ch[5]  = bus.data_in5;
    assign ch[6]  = bus.data_in6;
    assign ch[7]  = bus.data_in7;
    assign ch[8]  = bus.data_in8;
    assign ch[9]  = bus.data_in9;
    assign ch[10] = bus.data_in10;
    assign ch[11] = bus.data_in11;
    assign ch[12] = bus.data_in12;
    assign ch[13] = bus.data_in13;
    assign ch[14] = bus.data_in14;
    assign ch[15] = bus.data_in15;

    assign fill_fire = (state_q == FILL) && bus.valid_in;
    assign fill_last = fill_fire && (pos_cnt == POS_LAST);
    assign xfer      = (state_q == DRAIN) && bus.ready_out;
    assign last_word = (rd_idx == RD_LAST);

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (fill_last) begin
            state_d = DRAIN;
        end else if (xfer && last_word) begin
            state_d = FILL;
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pos_cnt    <= '0;
            rd_idx     <= '0;
            done_q     <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            done_q <= xfer && last_word;
            if (fill_fire) begin
                pos_cnt <= fill_last ? '0 : pos_cnt + 1'b1;
            end
            if (fill_last) begin
                rd_idx <= '0;
            end else if (xfer) begin
                rd_idx <= last_word ? '0 : rd_idx + 1'b1;
            end
            // Beats offered while draining are discarded; flag stays until reset
            if (bus.valid_in && (state_q == DRAIN)) begin
                drop_err_q <= 1'b1;
            end
        end
    end

    // NOTE: the feature store has no reset; every word is written before it is read.
    always_ff @(posedge clk) begin
        if (fill_fire) begin
            for (int c = 0; c < CHANNELS; c++) begin
                mem[{pos_cnt, CW'(c)}] <= ch[c];
            end
        end
    end

    assign bus.data_out  = (state_q == DRAIN) ? mem[rd_idx] : '0;
    assign bus.valid_out = (state_q == DRAIN);
    assign bus.last_out  = (state_q == DRAIN) && last_word;
    assign bus.in_ready  = (state_q == FILL);
    assign bus.done      = done_q;
    assign bus.drop_err  = drop_err_q;
endmodule

// File: tb/tb_flatten_buffer_layer3.sv
// Scoreboard bench for flatten_buffer_layer3: an image-level model queues the
// expected flattened words; a negedge monitor compares every presented output.
module tb_flatten_buffer_layer3;
    localparam int DW    = 32;
    localparam int POS   = 16;
    localparam int CH    = 16;
    localparam int WORDS = POS * CH;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    flatten_buffer_layer3_if #(.DATA_WIDTH(DW)) bus ();

    flatten_buffer_layer3 #(
        .DATA_WIDTH(DW),
        .POSITIONS (POS)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    function automatic logic [DW-1:0] in_word(input int c);
        case (c)
            0: return bus.data_in0;    1: return bus.data_in1;
            2: return bus.data_in2;    3: return bus.data_in3;
            4: return bus.data_in4;    5: return bus.data_in5;
            6: return bus.data_in6;    7: return bus.data_in7;
            8: return bus.data_in8;    9: return bus.data_in9;
            10: return bus.data_in10;  11: return bus.data_in11;
            12: return bus.data_in12;  13: return bus.data_in13;
            14: return bus.data_in14;  default: return bus.data_in15;
        endcase
    endfunction

    task automatic drive_word(input int c, input logic [DW-1:0] v);
        case (c)
            0: bus.data_in0 = v;    1: bus.data_in1 = v;
            2: bus.data_in2 = v;    3: bus.data_in3 = v;
            4: bus.data_in4 = v;    5: bus.data_in5 = v;
            6: bus.data_in6 = v;    7: bus.data_in7 = v;
            8: bus.data_in8 = v;    9: bus.data_in9 = v;
            10: bus.data_in10 = v;  11: bus.data_in11 = v;
            12: bus.data_in12 = v;  13: bus.data_in13 = v;
            14: bus.data_in14 = v;  default: bus.data_in15 = v;
        endcase
    endtask

    // Reference model: an image is a POS x CH array; once complete it is queued
    // as a flat list and each accepted output word removes the head.
    bit            m_fill = 1'b1;
    int            m_pos  = 0;
    bit            m_drop = 1'b0;
    bit            m_done = 1'b0;
    int            m_xfer = 0;
    logic [DW-1:0] m_img [POS][CH];
    logic [DW-1:0] exp_q [$];
    bit            mon_en = 1'b0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_fill = 1'b1;
            m_pos  = 0;
            m_drop = 1'b0;
            m_done = 1'b0;
            m_xfer = 0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_fill) begin
                if (bus.valid_in) begin
                    for (int c = 0; c < CH; c++) m_img[m_pos][c] = in_word(c);
                    m_pos++;
                    if (m_pos == POS) begin
                        for (int p = 0; p < POS; p++)
                            for (int c = 0; c < CH; c++) exp_q.push_back(m_img[p][c]);
                        m_pos  = 0;
                        m_fill = 1'b0;
                        m_xfer = 0;
                    end
                end
            end else begin
                if (bus.valid_in) m_drop = 1'b1;
                if (bus.ready_out && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    m_xfer++;
                    if (exp_q.size() == 0) begin
                        m_fill = 1'b1;
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("valid_out", bus.valid_out, !m_fill);
            check("in_ready", bus.in_ready, m_fill);
            check("drop_err", bus.drop_err, m_drop);
            check("done", bus.done, m_done);
            if (!m_fill && exp_q.size() > 0) begin
                check("data_out", bus.data_out, exp_q[0]);
                check("last_out", bus.last_out, exp_q.size() == 1);
            end else begin
                check("data_out_idle", bus.data_out, '0);
                check("last_out_idle", bus.last_out, 1'b0);
            end
        end
    end

    // Downstream ready: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random
    int rmode = 0;
    initial begin
        bit [3:0] pat = 4'b1001;
        int cyc = 0;
        bus.ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1:       bus.ready_out = pat[cyc % 4];
                2:       bus.ready_out = 1'($urandom_range(0, 1));
                default: bus.ready_out = 1'b1;
            endcase
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"}, bus.data_out, '0);
        check({tag, "_valid_out"}, bus.valid_out, 1'b0);
        check({tag, "_last_out"}, bus.last_out, 1'b0);
        check({tag, "_done"}, bus.done, 1'b0);
        check({tag, "_drop_err"}, bus.drop_err, 1'b0);
        check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    endtask

    task automatic do_reset(input string tag);
        resetn = 1'b0;
        #1;
        check_reset_outputs(tag);
        tick();
        resetn = 1'b1;
    endtask

    // counting=1 gives data_inC = pos*16 + C, otherwise random words
    task automatic fill_image(input bit counting);
        for (int p = 0; p < POS; p++) begin
            for (int c = 0; c < CH; c++)
                drive_word(c, counting ? DW'(p * CH + c) : DW'($urandom));
            bus.valid_in = 1'b1;
            tick();
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(m_fill && exp_q.size() == 0) && n < 4000) begin
            tick();
            n++;
        end
        if (n >= 4000) timeout_fail(name);
    endtask

    task automatic wait_xfer(input string name, input int k);
        int n = 0;
        while (m_xfer != k && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) timeout_fail(name);
    endtask

    initial begin
        int n;
        bus.valid_in = 1'b0;
        for (int c = 0; c < CH; c++) drive_word(c, '0);
        resetn = 1'b1;
        #1;
        resetn = 1'b0;
        #12;
        check_reset_outputs("reset");
        tick();
        resetn = 1'b1;
        mon_en = 1'b1;

        // Counting image: words 0..255 in order
        fill_image(1'b1);
        wait_idle("fill_drain");

        // Backpressure pattern 1,0,0,1
        rmode = 1;
        fill_image(1'b0);
        wait_idle("backpressure");
        rmode = 0;

        // Overrun while word 5 is presented
        fill_image(1'b0);
        wait_xfer("overrun_wait", 5);
        for (int c = 0; c < CH; c++) drive_word(c, DW'($urandom));
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        wait_idle("overrun");
        check("drop_err_sticky", bus.drop_err, 1'b1);
        do_reset("reset2");

        // Back-to-back: next image starts the cycle done is high
        fill_image(1'b0);
        n = 0;
        while (!bus.done && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) timeout_fail("b2b_done");
        fill_image(1'b0);
        wait_idle("back_to_back");
        check("b2b_drop_err", bus.drop_err, 1'b0);

        // Random backpressure
        rmode = 2;
        fill_image(1'b0);
        wait_idle("random_ready");
        rmode = 0;

        // Reset while word 100 is presented, then a fresh image
        fill_image(1'b0);
        wait_xfer("mid_reset_wait", 100);
        check("pre_reset_valid", bus.valid_out, 1'b1);
        do_reset("mid_reset");
        fill_image(1'b1);
        wait_idle("after_reset");

        tick();
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
